// File: rtl/aes_cbc_axis_arbiter_pkg.sv
// Shared types and constants for the two-channel AES-CBC stream arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package aes_cbc_axis_arbiter_pkg;

  localparam int AES_BLOCK_SIZE    = 128;
  localparam int AES256_KEY_LENGTH = 256;

  // One-hot so that each state decodes from a single flop.
  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_IN   = 3'b010,
    ST_OUT  = 3'b100
  } arb_state_t;

endpackage

// File: rtl/aes_cbc_axis_arbiter_rr.sv
// Two-input round-robin pick: a lone requester wins, a tie goes to the channel not served last.
// Latency: combinational; the parent registers the result.
// Backpressure: none, pure function of the request vector.
module aes_rr_arbiter2
  import aes_cbc_axis_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       gnt_vld_o,
  output logic       gnt_o
);

  // Channel 1 wins when it is alone, or when both ask and channel 0 was served last.
  always_comb begin
    gnt_vld_o = |req_i;
    gnt_o     = req_i[1] & (~req_i[0] | ~last_grant_i);
  end

endmodule

// File: rtl/aes_cbc_axis_arbiter.sv
// Shares one AES-CBC core between two AXI-Stream requesters, one whole message at a time.
// Latency: 1 cycle to arbitrate, then combinational pass-through in both directions.
// Backpressure: granted input sees core tready; granted output drives core tready; others are held off.
module aes_cbc_axis_arbiter
  import aes_cbc_axis_arbiter_pkg::*;
#(
  parameter int AXIS_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  // requester inputs
  input  logic [AXIS_WIDTH-1:0]   s0_tdata_i,
  input  logic [AXIS_WIDTH/8-1:0] s0_tkeep_i,
  input  logic                    s0_tlast_i,
  input  logic                    s0_tuser_i,
  input  logic                    s0_tvalid_i,
  output logic                    s0_tready_o,
  input  logic [AXIS_WIDTH-1:0]   s1_tdata_i,
  input  logic [AXIS_WIDTH/8-1:0] s1_tkeep_i,
  input  logic                    s1_tlast_i,
  input  logic                    s1_tuser_i,
  input  logic                    s1_tvalid_i,
  output logic                    s1_tready_o,
  // requester result streams
  output logic [AXIS_WIDTH-1:0]   m0_tdata_o,
  output logic [AXIS_WIDTH/8-1:0] m0_tkeep_o,
  output logic                    m0_tlast_o,
  output logic                    m0_tvalid_o,
  input  logic                    m0_tready_i,
  output logic [AXIS_WIDTH-1:0]   m1_tdata_o,
  output logic [AXIS_WIDTH/8-1:0] m1_tkeep_o,
  output logic                    m1_tlast_o,
  output logic                    m1_tvalid_o,
  input  logic                    m1_tready_i,
  // core input side
  output logic [AXIS_WIDTH-1:0]   core_s_tdata_o,
  output logic [AXIS_WIDTH/8-1:0] core_s_tkeep_o,
  output logic                    core_s_tlast_o,
  output logic                    core_s_tuser_o,
  output logic                    core_s_tvalid_o,
  input  logic                    core_s_tready_i,
  // core output side
  input  logic [AXIS_WIDTH-1:0]   core_m_tdata_i,
  input  logic [AXIS_WIDTH/8-1:0] core_m_tkeep_i,
  input  logic                    core_m_tlast_i,
  input  logic                    core_m_tvalid_i,
  output logic                    core_m_tready_o,
  // status
  output logic                    grant_o,
  output logic                    busy_o,
  output logic [CNT_WIDTH-1:0]    msg_cnt0_o,
  output logic [CNT_WIDTH-1:0]    msg_cnt1_o
);

  arb_state_t           state_q, state_d;
  logic                 grant_q, grant_d;
  logic                 last_grant_q, last_grant_d;
  logic [CNT_WIDTH-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic                 arb_vld, arb_gnt;
  logic                 in_open, out_open, in_done, out_done;

  aes_rr_arbiter2 u_rr (
    .req_i        ({s1_tvalid_i, s0_tvalid_i}),
    .last_grant_i (last_grant_q),
    .gnt_vld_o    (arb_vld),
    .gnt_o        (arb_gnt)
  );

  // The output path stays open through ST_IN as well: the core only answers after tlast,
  // so nothing arrives early, but a granted channel must never lose a beat.
  assign in_open  = (state_q == ST_IN);
  assign out_open = (state_q != ST_IDLE);
  assign in_done  = in_open & core_s_tvalid_o & core_s_tready_i & core_s_tlast_o;
  assign out_done = (state_q == ST_OUT) & core_m_tvalid_i & core_m_tready_o & core_m_tlast_i;

  // Input mux: only the granted requester reaches the core, and only while the message is inbound.
  always_comb begin
    core_s_tvalid_o = 1'b0;
    core_s_tdata_o  = '0;
    core_s_tkeep_o  = '0;
    core_s_tlast_o  = 1'b0;
    core_s_tuser_o  = 1'b0;
    s0_tready_o     = 1'b0;
    s1_tready_o     = 1'b0;
    if (in_open) begin
      if (grant_q) begin
        core_s_tvalid_o = s1_tvalid_i;
        core_s_tdata_o  = s1_tdata_i;
        core_s_tkeep_o  = s1_tkeep_i;
        core_s_tlast_o  = s1_tlast_i;
        core_s_tuser_o  = s1_tuser_i;
        s1_tready_o     = core_s_tready_i;
      end else begin
        core_s_tvalid_o = s0_tvalid_i;
        core_s_tdata_o  = s0_tdata_i;
        core_s_tkeep_o  = s0_tkeep_i;
        core_s_tlast_o  = s0_tlast_i;
        core_s_tuser_o  = s0_tuser_i;
        s0_tready_o     = core_s_tready_i;
      end
    end
  end

  // Output demux: core results go back to the granted channel; the other channel reads all zeros.
  always_comb begin
    m0_tvalid_o     = 1'b0;
    m0_tdata_o      = '0;
    m0_tkeep_o      = '0;
    m0_tlast_o      = 1'b0;
    m1_tvalid_o     = 1'b0;
    m1_tdata_o      = '0;
    m1_tkeep_o      = '0;
    m1_tlast_o      = 1'b0;
    core_m_tready_o = 1'b0;
    if (out_open) begin
      if (grant_q) begin
        m1_tvalid_o     = core_m_tvalid_i;
        m1_tdata_o      = core_m_tdata_i;
        m1_tkeep_o      = core_m_tkeep_i;
        m1_tlast_o      = core_m_tlast_i;
        core_m_tready_o = m1_tready_i;
      end else begin
        m0_tvalid_o     = core_m_tvalid_i;
        m0_tdata_o      = core_m_tdata_i;
        m0_tkeep_o      = core_m_tkeep_i;
        m0_tlast_o      = core_m_tlast_i;
        core_m_tready_o = m0_tready_i;
      end
    end
  end

  // Next state: grant from idle, close input on tlast in, release and count on tlast out.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt0_d       = cnt0_q;
    cnt1_d       = cnt1_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_vld) begin
          grant_d = arb_gnt;
          state_d = ST_IN;
        end
      end
      ST_IN: begin
        if (in_done) state_d = ST_OUT;
      end
      ST_OUT: begin
        if (out_done) begin
          state_d      = ST_IDLE;
          last_grant_d = grant_q;
          if (grant_q) cnt1_d = cnt1_q + CNT_WIDTH'(1);
          else         cnt0_d = cnt0_q + CNT_WIDTH'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; last_grant starts at 1 so channel 0 wins the first tie.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end

  assign busy_o     = out_open;
  assign grant_o    = grant_q;
  assign msg_cnt0_o = cnt0_q;
  assign msg_cnt1_o = cnt1_q;

endmodule

// File: tb/tb_aes_cbc_axis_arbiter.sv
// Bench for the two-channel AES-CBC arbiter with a half-duplex stand-in core.
// The stand-in buffers text beats and returns them XOR a tuser-dependent mask after tlast.
// Scoreboard queues per channel hold the expected result beats.
module tb_aes_cbc_axis_arbiter;

  localparam int W     = 8;
  localparam int KW    = W / 8;
  localparam int CW    = 4;
  localparam int BPB   = 128 / W;
  localparam int BEAT_LIMIT  = 1000;
  localparam int DRAIN_LIMIT = 3000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0][W-1:0]  s_tdata;
  logic [1:0][KW-1:0] s_tkeep;
  logic [1:0]         s_tlast, s_tuser, s_tvalid, s_tready;
  logic [1:0][W-1:0]  m_tdata;
  logic [1:0][KW-1:0] m_tkeep;
  logic [1:0]         m_tlast, m_tvalid, m_tready;
  logic [W-1:0]       core_s_tdata, core_m_tdata;
  logic [KW-1:0]      core_s_tkeep, core_m_tkeep;
  logic               core_s_tlast, core_s_tuser, core_s_tvalid, core_s_tready;
  logic               core_m_tlast, core_m_tvalid, core_m_tready;
  logic               grant, busy;
  logic [CW-1:0]      cnt0, cnt1;

  aes_cbc_axis_arbiter #(.AXIS_WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .s0_tdata_i(s_tdata[0]), .s0_tkeep_i(s_tkeep[0]), .s0_tlast_i(s_tlast[0]),
    .s0_tuser_i(s_tuser[0]), .s0_tvalid_i(s_tvalid[0]), .s0_tready_o(s_tready[0]),
    .s1_tdata_i(s_tdata[1]), .s1_tkeep_i(s_tkeep[1]), .s1_tlast_i(s_tlast[1]),
    .s1_tuser_i(s_tuser[1]), .s1_tvalid_i(s_tvalid[1]), .s1_tready_o(s_tready[1]),
    .m0_tdata_o(m_tdata[0]), .m0_tkeep_o(m_tkeep[0]), .m0_tlast_o(m_tlast[0]),
    .m0_tvalid_o(m_tvalid[0]), .m0_tready_i(m_tready[0]),
    .m1_tdata_o(m_tdata[1]), .m1_tkeep_o(m_tkeep[1]), .m1_tlast_o(m_tlast[1]),
    .m1_tvalid_o(m_tvalid[1]), .m1_tready_i(m_tready[1]),
    .core_s_tdata_o(core_s_tdata), .core_s_tkeep_o(core_s_tkeep), .core_s_tlast_o(core_s_tlast),
    .core_s_tuser_o(core_s_tuser), .core_s_tvalid_o(core_s_tvalid), .core_s_tready_i(core_s_tready),
    .core_m_tdata_i(core_m_tdata), .core_m_tkeep_i(core_m_tkeep), .core_m_tlast_i(core_m_tlast),
    .core_m_tvalid_i(core_m_tvalid), .core_m_tready_o(core_m_tready),
    .grant_o(grant), .busy_o(busy), .msg_cnt0_o(cnt0), .msg_cnt1_o(cnt1)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int stray = 0;
  int keep_err = 0;
  bit gaps = 1'b0;
  bit abort = 1'b0;
  logic [1:0] drv_act = 2'b00;
  logic [KW+W:0] exp_q0[$];
  logic [KW+W:0] exp_q1[$];
  logic grant_log[$];

  function automatic logic [W-1:0] xmask(input logic u);
    return u ? {KW{8'hA5}} : {KW{8'h5A}};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int ch, input logic [KW+W:0] v);
    if (ch == 0) exp_q0.push_back(v);
    else         exp_q1.push_back(v);
  endtask

  // ---------------- stand-in core: absorb whole message, then replay text ----------------
  logic [W-1:0] cq[$];
  int           core_beat;
  logic         core_tx, cs_rdy_q, cm_vld_q, cm_last_q;
  logic [W-1:0] cm_dat_q;

  assign core_s_tready = !core_tx && cs_rdy_q;
  assign core_m_tvalid = cm_vld_q;
  assign core_m_tdata  = cm_dat_q;
  assign core_m_tkeep  = '1;
  assign core_m_tlast  = cm_last_q;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cq.delete();
      core_beat <= 0;
      core_tx   <= 1'b0;
      cs_rdy_q  <= 1'b0;
      cm_vld_q  <= 1'b0;
      cm_last_q <= 1'b0;
      cm_dat_q  <= '0;
    end else begin
      cs_rdy_q <= gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      if (core_s_tvalid && core_s_tready) begin
        if (core_s_tkeep != {KW{1'b1}}) keep_err++;
        if (core_beat >= 3 * BPB) cq.push_back(core_s_tdata ^ xmask(core_s_tuser));
        core_beat <= core_beat + 1;
        if (core_s_tlast) begin
          core_tx   <= 1'b1;
          core_beat <= 0;
        end
      end
      if (core_tx) begin
        if (cm_vld_q && core_m_tready && cm_last_q) begin
          cm_vld_q <= 1'b0;
          core_tx  <= 1'b0;
        end else if (!cm_vld_q || core_m_tready) begin
          if (cq.size() > 0 && (!gaps || $urandom_range(0, 1) == 1)) begin
            cm_dat_q  <= cq.pop_front();
            cm_last_q <= (cq.size() == 0);
            cm_vld_q  <= 1'b1;
          end else begin
            cm_vld_q <= 1'b0;
          end
        end
      end
    end
  end

  // ---------------- requester driver ----------------
  task automatic send_msg(input int ch, input logic tuser, input int nblk, input bit gp);
    int nb;
    int w;
    logic [W-1:0] d;
    nb = (3 + nblk) * BPB;
    drv_act[ch] = 1'b1;
    for (int i = 0; i < nb; i++) begin
      d = W'($urandom);
      if (gp) begin
        while ($urandom_range(0, 1) == 0) begin
          s_tvalid[ch] = 1'b0;
          @(negedge clk);
        end
      end
      if (i >= 3 * BPB) push_exp(ch, {(i == nb - 1), {KW{1'b1}}, d ^ xmask(tuser)});
      s_tdata[ch]  = d;
      s_tkeep[ch]  = '1;
      s_tlast[ch]  = (i == nb - 1);
      s_tuser[ch]  = tuser;
      s_tvalid[ch] = 1'b1;
      #1;
      w = 0;
      while (!s_tready[ch] && !abort && w < BEAT_LIMIT) begin
        @(negedge clk);
        #1;
        w++;
      end
      if (abort) break;
      if (w >= BEAT_LIMIT) begin
        chk($sformatf("s%0d_accept_timeout", ch), s_tready[ch], 1);
        break;
      end
      @(negedge clk);
    end
    s_tvalid[ch] = 1'b0;
    s_tlast[ch]  = 1'b0;
    drv_act[ch]  = 1'b0;
  endtask

  // ---------------- result sinks: pop scoreboard on every accepted beat ----------------
  task automatic sink(input int ch);
    logic [KW+W:0] e;
    forever begin
      @(negedge clk);
      m_tready[ch] = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (rst_n && m_tvalid[ch] && m_tready[ch]) begin
        if ((ch == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0)) begin
          chk($sformatf("m%0d_unexpected_beat", ch), m_tvalid[ch], 0);
        end else begin
          e = (ch == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          chk($sformatf("m%0d_beat", ch), {m_tlast[ch], m_tkeep[ch], m_tdata[ch]}, e);
        end
      end
    end
  endtask

  // Logs each new grant and counts cycles where an idle channel or idle core sees activity.
  task automatic monitor();
    logic busy_prev;
    busy_prev = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        busy_prev = 1'b0;
      end else begin
        if (busy && !busy_prev) grant_log.push_back(grant);
        busy_prev = busy;
        if (busy) begin
          if (m_tvalid[!grant] || s_tready[!grant] || m_tdata[!grant] != '0) stray++;
        end else if (core_s_tvalid || core_m_tready || s_tready != 2'b00) begin
          stray++;
        end
      end
    end
  endtask

  task automatic wait_done(input string name);
    int cyc;
    cyc = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0 || busy) && cyc < DRAIN_LIMIT) begin
      @(negedge clk);
      cyc++;
    end
    chk({name, "_busy_after_drain"}, busy, 0);
    chk({name, "_beats_pending"}, exp_q0.size() + exp_q1.size(), 0);
  endtask

  typedef struct {
    int   ch;
    logic tuser;
    int   nblk;
    bit   gp;
    int   exp_cnt0;
    int   exp_cnt1;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #800000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    int cyc;
    int g;
    // counters start at 2/2 after the contention sequence
    vecs[0] = '{0, 1'b1, 1, 1'b0, 3, 2};
    vecs[1] = '{1, 1'b0, 1, 1'b0, 3, 3};
    vecs[2] = '{0, 1'b0, 3, 1'b1, 4, 3};
    vecs[3] = '{1, 1'b1, 3, 1'b1, 4, 4};
    vecs[4] = '{1, 1'b1, 2, 1'b1, 4, 5};
    vecs[5] = '{0, 1'b1, 2, 1'b0, 5, 5};

    s_tvalid = '0; s_tdata = '0; s_tkeep = '1; s_tlast = '0; s_tuser = '0;
    m_tready = '0;
    rst_n = 1'b0;
    fork
      sink(0);
      sink(1);
      monitor();
    join_none

    // reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_cnt0", cnt0, 0);
    chk("rst_cnt1", cnt1, 0);
    chk("rst_core_s_tvalid", core_s_tvalid, 0);
    chk("rst_core_m_tready", core_m_tready, 0);
    chk("rst_s_tready", s_tready, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    @(negedge clk);

    // both channels request from reset: channel 0 first, then strict alternation
    rst_n = 1'b1;
    grant_log.delete();
    fork
      begin send_msg(0, 1'b1, 1, 1'b0); send_msg(0, 1'b0, 1, 1'b0); end
      begin send_msg(1, 1'b1, 1, 1'b0); send_msg(1, 1'b0, 2, 1'b0); end
    join
    wait_done("contention");
    chk("contention_grants", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      chk($sformatf("contention_grant%0d", i), grant_log[i], i % 2);
    chk("contention_cnt0", cnt0, 2);
    chk("contention_cnt1", cnt1, 2);

    // single-channel messages, with and without flow-control gaps
    for (int i = 0; i < 6; i++) begin
      gaps = vecs[i].gp;
      grant_log.delete();
      send_msg(vecs[i].ch, vecs[i].tuser, vecs[i].nblk, vecs[i].gp);
      wait_done($sformatf("vec%0d", i));
      g = (grant_log.size() == 1) ? int'(grant_log[0]) : 2;
      chk($sformatf("vec%0d_grant", i), g, vecs[i].ch);
      chk($sformatf("vec%0d_cnt0", i), cnt0, vecs[i].exp_cnt0);
      chk($sformatf("vec%0d_cnt1", i), cnt1, vecs[i].exp_cnt1);
    end
    gaps = 1'b0;

    // reset while channel 1 is mid-input
    fork
      send_msg(1, 1'b1, 2, 1'b0);
    join_none
    cyc = 0;
    while (!(busy && grant) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    repeat (4) @(negedge clk);
    chk("mid_grant", grant, 1);
    chk("mid_core_s_tvalid", core_s_tvalid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_core_s_tvalid", core_s_tvalid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_s1_tready", s_tready[1], 0);
    chk("mid_rst_m_tvalid", m_tvalid, 0);
    chk("mid_rst_core_m_tready", core_m_tready, 0);
    chk("mid_rst_cnt1", cnt1, 0);
    abort = 1'b1;
    cyc = 0;
    while (drv_act[1] && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    abort = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send_msg(0, 1'b0, 1, 1'b0);
    wait_done("post_rst");
    chk("post_rst_cnt0", cnt0, 1);
    chk("post_rst_cnt1", cnt1, 0);

    // counter wrap on channel 0
    for (int k = 0; k < 14; k++) begin
      send_msg(0, 1'b1, 1, 1'b0);
      wait_done("wrap_fill");
    end
    chk("wrap_cnt0_max", cnt0, (1 << CW) - 1);
    send_msg(0, 1'b1, 1, 1'b0);
    wait_done("wrap_last");
    chk("wrap_cnt0_zero", cnt0, 0);
    chk("wrap_cnt1", cnt1, 0);

    chk("stray_activity_cycles", stray, 0);
    chk("core_keep_errors", keep_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
